// File: rtl/icache_fetch_responder.sv
// Direct-mapped, read-only instruction cache seen from the fetch stage: combinational
// lookup with a byte-aligned 64-bit window, plus a beat-based line refill engine.
module icache_fetch_responder #(
    parameter int PC_BITS     = 32,
    parameter int FETCH_WIDTH = 64,
    parameter int LINE_BYTES  = 32,
    parameter int SETS        = 64,
    parameter int MEM_BITS    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_BITS-1:0]     current_PC,
    output logic                   Hit_cache,
    output logic                   Miss,
    output logic                   partial_access,
    output logic [1:0]             partial_type,
    output logic [FETCH_WIDTH-1:0] fetched_data,
    input  logic                   invalidate_all,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [PC_BITS-1:0]     mem_req_addr,
    input  logic                   mem_resp_valid,
    input  logic [MEM_BITS-1:0]    mem_resp_data,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count,
    output logic [1:0]             fsm_state
);

    localparam int OFF       = $clog2(LINE_BYTES);
    localparam int IDX       = $clog2(SETS);
    localparam int TAG       = PC_BITS - OFF - IDX;
    localparam int LINE_BITS = LINE_BYTES * 8;
    localparam int BEATS     = LINE_BITS / MEM_BITS;
    localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2
    } state_t;

    state_t               state;
    logic [SETS-1:0]      valid_q;
    logic [TAG-1:0]       tag_q  [SETS];
    logic [LINE_BITS-1:0] data_q [SETS];
    logic                 stale_q;
    logic [BW-1:0]        beat_q;

    logic [OFF-1:0]         pc_off;
    logic [IDX-1:0]         pc_idx;
    logic [TAG-1:0]         pc_tag;
    logic [IDX-1:0]         fill_idx;
    logic [TAG-1:0]         fill_tag;
    logic [OFF:0]           rem;
    logic                   partial;
    logic                   hit;
    logic                   beat_fire;
    logic                   last_beat;
    logic [FETCH_WIDTH-1:0] window;

    assign pc_off   = current_PC[OFF-1:0];
    assign pc_idx   = current_PC[OFF+IDX-1:OFF];
    assign pc_tag   = current_PC[PC_BITS-1:OFF+IDX];
    assign fill_idx = mem_req_addr[OFF+IDX-1:OFF];
    assign fill_tag = mem_req_addr[PC_BITS-1:OFF+IDX];

    assign hit       = (state == S_IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign rem       = (OFF+1)'(LINE_BYTES) - {1'b0, pc_off};
    assign partial   = rem < (OFF+1)'(8);
    // Zero-extending the line above its top byte makes the bytes past the line end read as 0.
    assign window    = FETCH_WIDTH'({{FETCH_WIDTH{1'b0}}, data_q[pc_idx]} >> {pc_off, 3'b000});
    assign beat_fire = (state == S_FILL) && mem_resp_valid;
    assign last_beat = beat_fire && (beat_q == BW'(BEATS - 1));

    assign Hit_cache      = hit;
    assign Miss           = ~hit;
    assign partial_access = hit && partial;
    assign partial_type   = (hit && partial) ? rem[2:1] : 2'b00;
    assign fetched_data   = hit ? window : '0;
    assign fsm_state      = state;

    // Request handshake: mem_req_valid rises with a stable mem_req_addr and holds both
    // until the cycle mem_req_ready is also high; that cycle transfers the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            valid_q       <= '0;
            stale_q       <= 1'b0;
            beat_q        <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            if (hit)
                hit_count <= hit_count + 32'd1;
            if (invalidate_all)
                valid_q <= '0;
            if (invalidate_all && state != S_IDLE)
                stale_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (!hit) begin
                        state           <= S_REQ;
                        mem_req_valid   <= 1'b1;
                        mem_req_addr    <= {current_PC[PC_BITS-1:OFF], {OFF{1'b0}}};
                        valid_q[pc_idx] <= 1'b0;
                        miss_count      <= miss_count + 32'd1;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        state         <= S_FILL;
                        mem_req_valid <= 1'b0;
                        beat_q        <= '0;
                    end
                end
                S_FILL: begin
                    if (beat_fire)
                        beat_q <= beat_q + 1'b1;
                    if (last_beat) begin
                        state   <= S_IDLE;
                        stale_q <= 1'b0;
                        if (!stale_q && !invalidate_all)
                            valid_q[fill_idx] <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line storage carries no reset; valid_q alone decides whether contents are visible.
    always_ff @(posedge clk) begin
        if (beat_fire)
            data_q[fill_idx][beat_q*MEM_BITS +: MEM_BITS] <= mem_resp_data;
        if (last_beat)
            tag_q[fill_idx] <= fill_tag;
    end

    pc_even_a: assert property (@(posedge clk) disable iff (rst) current_PC[0] == 1'b0);

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Bench for icache_fetch_responder: directed scenarios then random fetches, checked against
// a line-level cache model and a hashed byte-addressed memory image.
module tb_icache_fetch_responder;

    localparam int LINE_BYTES = 32;
    localparam int SETS       = 64;
    localparam int BEATS      = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] current_PC;
    logic        Hit_cache;
    logic        Miss;
    logic        partial_access;
    logic [1:0]  partial_type;
    logic [63:0] fetched_data;
    logic        invalidate_all;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [1:0]  fsm_state;

    int          checks = 0;
    int          errors = 0;
    bit          model_valid [SETS];
    logic [31:0] model_line  [SETS];
    int unsigned model_hits   = 0;
    int unsigned model_misses = 0;

    icache_fetch_responder dut (
        .clk            (clk),
        .rst            (rst),
        .current_PC     (current_PC),
        .Hit_cache      (Hit_cache),
        .Miss           (Miss),
        .partial_access (partial_access),
        .partial_type   (partial_type),
        .fetched_data   (fetched_data),
        .invalidate_all (invalidate_all),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count),
        .fsm_state      (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic next();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        h = (a ^ 32'h5bd1e995) * 32'h9e3779b1;
        return h[23:16];
    endfunction

    function automatic logic [63:0] beat_data(input logic [31:0] line, input int b);
        logic [63:0] d;
        for (int j = 0; j < 8; j++)
            d[j*8 +: 8] = mem_byte(line + 32'(b*8 + j));
        return d;
    endfunction

    function automatic int set_of(input logic [31:0] pc);
        return int'((pc / LINE_BYTES) % SETS);
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] pc);
        return pc - (pc % LINE_BYTES);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return model_valid[set_of(pc)] && (model_line[set_of(pc)] == line_of(pc));
    endfunction

    function automatic logic [63:0] exp_window(input logic [31:0] pc);
        int          rem;
        logic [63:0] w;
        rem = LINE_BYTES - int'(pc % LINE_BYTES);
        w = '0;
        for (int i = 0; i < 8; i++)
            if (i < rem) w[i*8 +: 8] = mem_byte(pc + 32'(i));
        return w;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) model_valid[s] = 1'b0;
    endtask

    task automatic lookup_checks(input logic [31:0] pc, output bit exp_hit);
        int rem;
        exp_hit = model_hit(pc);
        rem = LINE_BYTES - int'(pc % LINE_BYTES);
        check("hit_count", 64'(hit_count), 64'(model_hits));
        check("miss_count", 64'(miss_count), 64'(model_misses));
        check("hit", 64'(Hit_cache), 64'(exp_hit));
        check("miss", 64'(Miss), 64'(!exp_hit));
        check("req_valid_idle", 64'(mem_req_valid), 64'(0));
        check("fsm_idle", 64'(fsm_state), 64'(0));
        if (exp_hit) begin
            check("data", fetched_data, exp_window(pc));
            check("partial", 64'(partial_access), 64'(rem < 8));
            check("ptype", 64'(partial_type), (rem < 8) ? 64'(rem / 2) : 64'(0));
        end else begin
            check("data_miss", fetched_data, 64'(0));
            check("partial_miss", 64'(partial_access), 64'(0));
            check("ptype_miss", 64'(partial_type), 64'(0));
        end
    endtask

    task automatic refill(input logic [31:0] pc, input bit rnd, input int inval_beat,
                          input int rst_beat);
        logic [31:0] line;
        int          idx;
        int          dly;
        int          gap;
        bit          stale;
        line = line_of(pc);
        idx = set_of(pc);
        model_misses++;
        model_valid[idx] = 1'b0;
        stale = 1'b0;
        dly = rnd ? int'($urandom_range(0, 3)) : 0;
        for (int d = 0; d <= dly; d++) begin
            next();
            mem_req_ready = (d == dly);
            mem_resp_valid = rnd && ($urandom_range(0, 1) == 1);
            mem_resp_data = {$urandom, $urandom};
            invalidate_all = 1'b0;
            #1;
            check("req_valid", 64'(mem_req_valid), 64'(1));
            check("req_addr", 64'(mem_req_addr), 64'(line));
            check("miss_in_req", 64'(Miss), 64'(1));
            check("miss_count_req", 64'(miss_count), 64'(model_misses));
        end
        for (int b = 0; b < BEATS; b++) begin
            gap = rnd ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gap; g++) begin
                next();
                mem_req_ready = 1'b0;
                mem_resp_valid = 1'b0;
                mem_resp_data = {$urandom, $urandom};
                invalidate_all = 1'b0;
                #1;
                check("req_valid_gap", 64'(mem_req_valid), 64'(0));
                check("miss_in_gap", 64'(Miss), 64'(1));
            end
            next();
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b1;
            mem_resp_data = beat_data(line, b);
            invalidate_all = (b == inval_beat);
            if (b == rst_beat) begin
                rst = 1'b1;
                invalidate_all = 1'b0;
                next();
                mem_resp_valid = 1'b0;
                #1;
                check("rst_req_valid", 64'(mem_req_valid), 64'(0));
                check("rst_hit_count", 64'(hit_count), 64'(0));
                check("rst_miss_count", 64'(miss_count), 64'(0));
                check("rst_hit", 64'(Hit_cache), 64'(0));
                check("rst_miss", 64'(Miss), 64'(1));
                check("rst_fsm", 64'(fsm_state), 64'(0));
                model_clear();
                model_hits = 0;
                model_misses = 0;
                return;
            end
            if (invalidate_all) begin
                stale = 1'b1;
                model_clear();
            end
            #1;
            check("hit_in_fill", 64'(Hit_cache), 64'(0));
            check("req_valid_fill", 64'(mem_req_valid), 64'(0));
        end
        if (!stale) begin
            model_valid[idx] = 1'b1;
            model_line[idx] = line;
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input bit rnd, input int inval_beat,
                         input int rst_beat);
        bit done;
        bit exp_hit;
        int iv;
        int rb;
        done = 1'b0;
        iv = inval_beat;
        rb = rst_beat;
        for (int tries = 0; tries < 5 && !done; tries++) begin
            next();
            rst = 1'b0;
            current_PC = pc;
            invalidate_all = 1'b0;
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_data = {$urandom, $urandom};
            #1;
            lookup_checks(pc, exp_hit);
            if (exp_hit) begin
                model_hits++;
                done = 1'b1;
            end else begin
                refill(pc, rnd, iv, rb);
                iv = -1;
                rb = -1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL fetch_timeout observed=no_hit expected=hit pc=%h", pc);
        end
    endtask

    task automatic inval_idle(input logic [31:0] pc);
        bit exp_hit;
        next();
        current_PC = pc;
        invalidate_all = 1'b1;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        lookup_checks(pc, exp_hit);
        if (exp_hit) model_hits++;
        model_clear();
    endtask

    initial begin
        logic [31:0] pc;
        int          iv;
        rst = 1'b1;
        current_PC = 32'h100;
        invalidate_all = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        model_clear();
        repeat (3) next();

        // Cold miss right after reset, fixed-latency refill, then hit on 0x100.
        fetch(32'h100, 1'b0, -1, -1);
        // Partial windows at the end of the line, then a full window with rem=8.
        fetch(32'h11A, 1'b0, -1, -1);
        fetch(32'h11C, 1'b0, -1, -1);
        fetch(32'h11E, 1'b0, -1, -1);
        fetch(32'h118, 1'b0, -1, -1);
        fetch(32'h120, 1'b0, -1, -1);
        // Conflict on the same set evicts 0x100.
        fetch(32'h100 + LINE_BYTES * SETS, 1'b0, -1, -1);
        fetch(32'h104, 1'b0, -1, -1);
        // Invalidate on the second fill beat leaves the line invalid; a fresh request follows.
        fetch(32'h140, 1'b0, 1, -1);
        inval_idle(32'h140);
        fetch(32'h142, 1'b0, -1, -1);
        // Reset after two beats aborts the refill.
        fetch(32'h160, 1'b0, -1, 2);

        for (int n = 0; n < 60; n++) begin
            pc = 32'h1000 + 32'($urandom_range(0, 3)) * 32'h800
                 + 32'($urandom_range(0, 2)) * 32'(LINE_BYTES)
                 + 32'($urandom_range(0, 15)) * 32'd2;
            iv = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1;
            fetch(pc, 1'b1, iv, -1);
            if ($urandom_range(0, 9) == 0) inval_idle(pc);
        end

        next();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
